// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared widths, load-type encodings and pipeline register layout for MEM/WB.
package mem_wb_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5,
    LOAD_LWL  = 3'd6,
    LOAD_LWR  = 3'd7
  } load_op_t;
  typedef struct packed {
    logic                  wreg;
    logic [RegAddrBus-1:0] wd;
    logic [RegBus-1:0]     wdata;
    load_op_t              load_op;
    logic [1:0]            addr_lo;
    logic [RegBus-1:0]     rt;
  } pipe_t;
endpackage

// File: rtl/mem_wb_load_align.sv
// load_align: big-endian load byte/half selection, extension and LWL/LWR merging.
module load_align
  import mem_wb_pkg::*;
(
  input  load_op_t          load_op,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] m,
  input  logic [RegBus-1:0] rt,
  output logic [RegBus-1:0] data
);
  logic [7:0] b;
  logic [15:0] h;
  logic [4:0] sh_l, sh_r;
  assign sh_l = {addr_lo, 3'b000};
  assign sh_r = {~addr_lo, 3'b000};
  assign b = m[sh_r +: 8];
  assign h = addr_lo[1] ? m[15:0] : m[31:16];
  always_comb begin
    data = ZeroWord;
    case (load_op)
      LOAD_LB:  data = {{24{b[7]}}, b};
      LOAD_LBU: data = {24'h0, b};
      LOAD_LH:  data = {{16{h[15]}}, h};
      LOAD_LHU: data = {16'h0, h};
      LOAD_LW:  data = m;
      // LWL keeps the low rt bytes not covered by memory; LWR keeps the high ones
      LOAD_LWL: data = (m << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      LOAD_LWR: data = (m >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
      default:  data = ZeroWord;
    endcase
  end
endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with stall/flush bubbles and a read-data hold for WB stalls.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_stall,
  input  logic                  wb_stall,
  input  logic                  flush,
  input  logic                  mem_wreg,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [2:0]            mem_load_op,
  input  logic [1:0]            mem_addr_lo,
  input  logic [RegBus-1:0]     mem_rt,
  input  logic [RegBus-1:0]     ram_rdata,
  output logic                  wb_we,
  output logic [RegAddrBus-1:0] wb_waddr,
  output logic [RegBus-1:0]     wb_wdata
);
  pipe_t pipe;
  logic hold_valid;
  logic [RegBus-1:0] hold_data, m, aligned;
  logic advance, capture;
  assign advance = flush || !(mem_stall && wb_stall);
  assign capture = !flush && !mem_stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe       <= '0;
      hold_valid <= 1'b0;
      hold_data  <= ZeroWord;
    end else if (advance) begin
      pipe       <= capture ? pipe_t'{mem_wreg, mem_wd, mem_wdata, load_op_t'(mem_load_op), mem_addr_lo, mem_rt} : '0;
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_data  <= ram_rdata;
      hold_valid <= 1'b1;
    end
  end
  // the synchronous RAM only presents the word for one cycle, so a stalled load reads the hold copy
  assign m = hold_valid ? hold_data : ram_rdata;
  load_align u_align (
    .load_op(pipe.load_op),
    .addr_lo(pipe.addr_lo),
    .m(m),
    .rt(pipe.rt),
    .data(aligned)
  );
  assign wb_we    = pipe.wreg && (pipe.wd != '0);
  assign wb_waddr = pipe.wd;
  assign wb_wdata = (pipe.load_op == LOAD_NONE) ? pipe.wdata : aligned;
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed vectors against a byte-level behavioural model of the MEM/WB stage.
module tb_mem_wb;
  logic clk = 0, rst = 1;
  logic mem_stall = 0, wb_stall = 0, flush = 0, mem_wreg = 0;
  logic [4:0] mem_wd = 0;
  logic [31:0] mem_wdata = 0, mem_rt = 0, ram_rdata = 0;
  logic [2:0] mem_load_op = 0;
  logic [1:0] mem_addr_lo = 0;
  logic wb_we;
  logic [4:0] wb_waddr;
  logic [31:0] wb_wdata;
  int checks = 0, failures = 0;

  mem_wb dut (
    .clk(clk), .rst(rst), .mem_stall(mem_stall), .wb_stall(wb_stall), .flush(flush),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_load_op(mem_load_op),
    .mem_addr_lo(mem_addr_lo), .mem_rt(mem_rt), .ram_rdata(ram_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  // model of the instruction sitting in WB and of the captured read word
  logic mw = 0, mhv = 0;
  logic [4:0] md = 0;
  logic [31:0] mwd = 0, mrt = 0, mhd = 0;
  logic [2:0] mop = 0;
  logic [1:0] malo = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {mw, md, mwd, mop, malo, mrt, mhv, mhd} = '0;
    end else if (flush || (mem_stall && !wb_stall)) begin
      {mw, md, mwd, mop, malo, mrt, mhv} = '0;
    end else if (!mem_stall) begin
      {mw, md, mwd, mop, malo, mrt} = {mem_wreg, mem_wd, mem_wdata, mem_load_op, mem_addr_lo, mem_rt};
      mhv = 0;
    end else if (!mhv) begin
      mhd = ram_rdata;
      mhv = 1;
    end
  end

  function automatic logic [31:0] model_data(logic [2:0] op, logic [1:0] a, logic [31:0] m, logic [31:0] rt);
    logic [7:0] mb[4], rb[4];
    logic [15:0] h;
    logic [31:0] r;
    int k;
    k = int'(a);
    for (int i = 0; i < 4; i++) begin
      mb[i] = m[8*(3-i) +: 8];
      rb[i] = rt[8*(3-i) +: 8];
    end
    h = a[1] ? {mb[2], mb[3]} : {mb[0], mb[1]};
    r = 0;
    case (op)
      3'd1: r = {{24{mb[k][7]}}, mb[k]};
      3'd2: r = {24'h0, mb[k]};
      3'd3: r = {{16{h[15]}}, h};
      3'd4: r = {16'h0, h};
      3'd5: r = m;
      3'd6: for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = (k + i <= 3) ? mb[k+i] : rb[i];
      3'd7: for (int i = 0; i < 4; i++) r[8*(3-i) +: 8] = (i >= 3 - k) ? mb[i-(3-k)] : rb[i];
      default: r = mwd;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("we", {31'h0, wb_we}, {31'h0, mw && (md != 0)});
    chk("waddr", {27'h0, wb_waddr}, {27'h0, md});
    chk("wdata", wb_wdata, mop == 0 ? mwd : model_data(mop, malo, mhv ? mhd : ram_rdata, mrt));
  end

  task automatic issue(input logic w, input logic [4:0] d, input logic [31:0] wd, input logic [2:0] op,
                       input logic [1:0] a, input logic [31:0] rt, input logic [31:0] ram,
                       input logic [31:0] exp, input string name);
    {mem_wreg, mem_wd, mem_wdata, mem_load_op, mem_addr_lo, mem_rt} = {w, d, wd, op, a, rt};
    {flush, mem_stall, wb_stall} = 3'b000;
    @(posedge clk);
    #1 ram_rdata = ram;
    #1 chk(name, wb_wdata, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk("reset_we", {31'h0, wb_we}, 0);
    chk("reset_waddr", {27'h0, wb_waddr}, 0);
    chk("reset_wdata", wb_wdata, 0);
    rst = 0;
    issue(1, 5, 32'h12345678, 0, 0, 0, 0, 32'h12345678, "alu_pass");
    chk("alu_we", {31'h0, wb_we}, 1);
    chk("alu_waddr", {27'h0, wb_waddr}, 5);
    issue(1, 6, 0, 1, 1, 0, 32'h8899AABB, 32'hFFFFFF99, "lb_a1");
    issue(1, 6, 0, 2, 3, 0, 32'h8899AABB, 32'h000000BB, "lbu_a3");
    issue(1, 6, 0, 3, 2, 0, 32'h8899AABB, 32'hFFFFAABB, "lh_a2");
    issue(1, 6, 0, 4, 0, 0, 32'h8899AABB, 32'h00008899, "lhu_a0");
    issue(1, 8, 0, 6, 1, 32'hAABBCCDD, 32'h11223344, 32'h223344DD, "lwl_a1");
    issue(1, 8, 0, 7, 1, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122, "lwr_a1");
    issue(1, 8, 0, 6, 3, 32'hAABBCCDD, 32'h11223344, 32'h44BBCCDD, "lwl_a3");
    issue(1, 8, 0, 7, 0, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11, "lwr_a0");
    issue(1, 0, 32'h55, 0, 0, 0, 0, 32'h55, "wd0_data");
    chk("wd0_we", {31'h0, wb_we}, 0);
    issue(1, 3, 32'h33, 0, 0, 0, 0, 32'h33, "pre_bubble");
    {mem_stall, wb_stall} = 2'b10;
    @(posedge clk);
    #2 chk("mem_stall_bubble_we", {31'h0, wb_we}, 0);
    issue(1, 4, 32'h44, 0, 0, 0, 0, 32'h44, "pre_flush");
    {flush, mem_stall, wb_stall} = 3'b111;
    @(posedge clk);
    #2 chk("flush_wb_stall_we", {31'h0, wb_we}, 0);
    chk("flush_wb_stall_data", wb_wdata, 0);
    issue(1, 7, 0, 5, 2, 0, 32'hCAFEF00D, 32'hCAFEF00D, "lw_stall_0");
    {mem_stall, wb_stall} = 2'b11;
    @(posedge clk);
    #1 ram_rdata = 32'hDEADBEEF;
    #1 chk("lw_stall_1", wb_wdata, 32'hCAFEF00D);
    repeat (2) begin
      @(posedge clk);
      #2 chk("lw_stall_n", wb_wdata, 32'hCAFEF00D);
    end
    chk("lw_stall_we", {31'h0, wb_we}, 1);
    @(negedge clk);
    #1 rst = 1;
    #1 chk("async_rst_we", {31'h0, wb_we}, 0);
    chk("async_rst_waddr", {27'h0, wb_waddr}, 0);
    chk("async_rst_wdata", wb_wdata, 0);
    #1 rst = 0;
    issue(1, 9, 32'h0BADF00D, 0, 0, 0, 32'h12121212, 32'h0BADF00D, "post_rst");
    chk("post_rst_waddr", {27'h0, wb_waddr}, 9);
    issue(1, 10, 0, 5, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, "post_rst_lw");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
